serial_bit_feeder: RTL

Parallel-to-serial stage sitting directly upstream of the 1101 Moore sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `ser_out`, which drives the detector's `in` port. A one-word holding register allows back-to-back words with no idle cycle between them, so the detector sees a contiguous bit stream.

---
 rtl/serial_feeder_pkg.sv | 11 +
 rtl/word_hold_reg.sv | 29 ++
 rtl/serial_bit_feeder.sv | 103 ++++++++++
 3 files changed

// File: rtl/serial_feeder_pkg.sv
// Shared types and defaults for the parallel-to-serial feeder ahead of the 1101 detector.
package serial_feeder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      SHIFT = 1'b1
   } shift_state_t;

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry holding register: parks one word while the shifter is still busy with the previous one.
module word_hold_reg
   import serial_feeder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             take,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   // A load wins over a take so a same-edge refill leaves the entry occupied.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout <= '0;
         full <= 1'b0;
      end else if (load) begin
         dout <= din;
         full <= 1'b1;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_bit_feeder.sv
// Accepts WIDTH-bit words over valid/ready and streams them one bit per clock with no gap between words.
module serial_bit_feeder
   import serial_feeder_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   shift_state_t     state;
   logic [WIDTH-1:0] sh_data;
   logic [CW-1:0]    sh_cnt;
   logic             sh_full;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;

   logic             accept;
   logic             at_end;
   logic             reload_slot;
   logic             take_hold;
   logic             take_new;
   logic             hold_load;
   logic [WIDTH-1:0] next_word;
   logic             cur_bit;

   assign load_ready  = !hold_full;
   assign accept      = load_valid && load_ready;
   assign at_end      = (state == SHIFT) && (sh_cnt == LAST_CNT);
   assign reload_slot = (state == EMPTY) || at_end;

   // The held word is always older than anything arriving now, so it gets the shifter first.
   assign take_hold   = reload_slot && hold_full;
   assign take_new    = reload_slot && !hold_full && accept;
   assign hold_load   = accept && !take_new;
   assign next_word   = take_hold ? hold_data : load_data;

   word_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk  (clk),
      .rst  (rst),
      .load (hold_load),
      .take (take_hold),
      .din  (load_data),
      .dout (hold_data),
      .full (hold_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= EMPTY;
         sh_data <= '0;
         sh_cnt  <= '0;
         sh_full <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (take_hold || take_new) begin
                  state   <= SHIFT;
                  sh_data <= next_word;
                  sh_cnt  <= '0;
                  sh_full <= 1'b1;
               end
            end
            SHIFT: begin
               if (!at_end) begin
                  sh_data <= MSB_FIRST ? {sh_data[WIDTH-2:0], 1'b0}
                                       : {1'b0, sh_data[WIDTH-1:1]};
                  sh_cnt  <= sh_cnt + CW'(1);
               end else if (take_hold || take_new) begin
                  sh_data <= next_word;
                  sh_cnt  <= '0;
               end else begin
                  state   <= EMPTY;
                  sh_cnt  <= '0;
                  sh_full <= 1'b0;
               end
            end
            default: begin
               state   <= EMPTY;
               sh_full <= 1'b0;
            end
         endcase
      end
   end

   assign cur_bit   = MSB_FIRST ? sh_data[WIDTH-1] : sh_data[0];
   assign ser_out   = sh_full && cur_bit;
   assign ser_valid = sh_full;
   assign word_done = at_end;
   assign busy      = sh_full || hold_full;

endmodule
